// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM: fetch, decode, ALU/memory sequencing, retire count
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [31:0] ir,
    output logic        mdr_we,
    output logic [6:0]  opcode,
    output logic [9:0]  op,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic        rf_wd_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        trap,
    output logic [31:0] instret
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_LOADEXT = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 the ALU uses for plain address addition
    localparam logic [2:0] F3_ADDRESS = 3'b000;

    logic [2:0] state;
    logic [2:0] state_next;
    logic       legal;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_jump;

    assign opc     = ir[6:0];
    assign f3      = ir[14:12];
    assign f7      = ir[31:25];
    assign is_jump = (opc == OPC_JAL) || (opc == OPC_JALR);

    // instruction legality check applied in DECODE
    always_comb begin
        legal = 1'b0;
        case (opc)
            OPC_OP:     legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            OPC_LOAD:   legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            OPC_STORE:  legal = (f3 <= 3'b010);
            OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

    // next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  state_next = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if ((opc == OPC_LOAD) || (opc == OPC_STORE)) state_next = S_MEM;
                else if (opc == OPC_BRANCH)                  state_next = S_FETCH;
                else                                          state_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready) state_next = (opc == OPC_STORE) ? S_FETCH : S_LOADEXT;
            end
            S_LOADEXT: state_next = S_WB;
            S_WB:      state_next = S_FETCH;
            S_TRAP:    state_next = S_TRAP;
            default:   state_next = S_TRAP;
        endcase
    end

    // state, instruction register and retire counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            ir      <= 32'h0;
            instret <= 32'h0;
        end else begin
            state <= state_next;
            if ((state == S_FETCH) && mem_ready) ir <= mem_rdata;
            // every non-reset PC commit retires exactly one instruction
            if (pc_we) instret <= instret + 32'd1;
        end
    end

    // datapath controls decoded from state and IR; reset forces the PC load only
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        mdr_we       = 1'b0;
        opcode       = 7'h0;
        op           = 10'h0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        rf_wd_sel    = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        trap         = 1'b0;
        case (state)
            S_FETCH: mem_req = 1'b1;
            S_DECODE: opcode = opc;
            S_EXEC: begin
                opcode = opc;
                case (opc)
                    OPC_OP: op = {f3, f7};
                    OPC_OPIMM: begin
                        op        = ((f3 == 3'b001) || (f3 == 3'b101)) ? {f3, f7} : {f3, 7'b0};
                        alu_b_sel = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        op        = {F3_ADDRESS, 7'b0};
                        alu_b_sel = 1'b1;
                    end
                    OPC_JALR: alu_b_sel = 1'b1;
                    OPC_BRANCH: begin
                        op        = {f3, 7'b0};
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = branch_taken;
                    end
                    OPC_JAL, OPC_AUIPC: begin
                        alu_a_sel = 2'd1;
                        alu_b_sel = 1'b1;
                    end
                    OPC_LUI: alu_b_sel = 1'b1;
                    default: op = 10'h0;
                endcase
            end
            S_MEM: begin
                opcode       = opc;
                op           = {F3_ADDRESS, 7'b0};
                alu_b_sel    = 1'b1;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opc == OPC_STORE);
                if (mem_ready) begin
                    if (opc == OPC_STORE) pc_we  = 1'b1;
                    else                  mdr_we = 1'b1;
                end
            end
            S_LOADEXT: begin
                opcode    = OPC_LOAD;
                op        = {f3, 7'b0};
                alu_a_sel = 2'd2;
            end
            S_WB: begin
                opcode    = opc;
                rf_we     = (ir[11:7] != 5'd0);
                rf_wd_sel = is_jump;
                pc_we     = 1'b1;
                pc_sel    = is_jump;
            end
            S_TRAP:  trap = 1'b1;
            default: trap = 1'b0;
        endcase
        if (reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            mdr_we       = 1'b0;
            opcode       = 7'h0;
            op           = 10'h0;
            alu_a_sel    = 2'd0;
            alu_b_sel    = 1'b0;
            rf_we        = 1'b0;
            rf_wd_sel    = 1'b0;
            pc_we        = 1'b1;
            pc_sel       = 1'b0;
            trap         = 1'b0;
        end
    end

endmodule
